dpram_ctrl_param: RTL and testbench

//  Parametrised simple dual-port RAM (one write port, one read port) with a hardware clear engine.

---
 rtl/dpram_pkg.sv | 13 +
 rtl/dpram_rd_pipe.sv | 51 +++++
 rtl/dpram_ctrl_param.sv | 98 +++++++++
 tb/tb_dpram_ctrl_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Purpose: shared types and limits for the parametrised dual-port RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpram_pkg;

  // Clear engine states: CLEAR sweeps INIT_VAL through the array, READY serves we/re.
  typedef enum logic {CLEAR, READY} dpram_state_t;

  // Supported read latencies for the output pipeline.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Purpose: RD_LAT-stage data/valid register pipeline feeding the RAM read outputs.
// Latency: RD_LAT cycles from issue to rd_valid; one result per cycle sustained.
// Backpressure: none; every issued read completes, data_out holds when no read lands.
// Ports: clk, reset (async, active-high), issue/word (read accepted this cycle and its
//        word), data_out/rd_valid (registered result and its one-cycle strobe).
module dpram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  if (RD_LAT == 2) begin : g_two
    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_vld   <= 1'b0;
        s1_dat   <= '0;
        rd_valid <= 1'b0;
        data_out <= '0;
      end else begin
        s1_vld   <= issue;
        rd_valid <= s1_vld;
        if (issue)
          s1_dat <= word;
        // Output only moves when a result lands, so it holds between reads.
        if (s1_vld)
          data_out <= s1_dat;
      end
    end
  end else begin : g_one
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_valid <= 1'b0;
        data_out <= '0;
      end else begin
        rd_valid <= issue;
        if (issue)
          data_out <= word;
      end
    end
  end

endmodule

// File: rtl/dpram_ctrl_param.sv
// Purpose: simple dual-port RAM (1W/1R) with a hardware clear engine writing INIT_VAL everywhere.
// Latency: reads RD_LAT cycles (1 or 2); writes land at the edge; clear takes 2**ADDR_W cycles.
// Backpressure: busy high during clear; we/re presented while busy are dropped silently.
// Ports: clk, reset (async, active-high), clear_req (start clear, READY only),
//        we/wr_addr/data_in (write port), re/rd_addr (read port),
//        data_out/rd_valid (read result + strobe), busy (clear engine running).
module dpram_ctrl_param
  import dpram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                RD_LAT   = 1,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("dpram_ctrl_param: RD_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  dpram_state_t      state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_issue;
  logic              collide;
  logic [DATA_W-1:0] rd_word;

  // Ports are only live once the clear engine has finished.
  assign rd_issue = re && (state == READY);
  assign collide  = we && (wr_addr == rd_addr);
  // Write-first forwards the incoming word; otherwise the array still holds the old one.
  assign rd_word  = ((BYPASS != 0) && collide) ? data_in : mem[rd_addr];

  // The array itself is never reset; the clear engine owns initialisation.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_cnt] <= INIT_VAL;
    else if (we)
      mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          // Wraps to 0 naturally after the last word.
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  dpram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .issue    (rd_issue),
    .word     (rd_word),
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_dpram_ctrl_param.sv
// Purpose: directed self-checking bench for dpram_ctrl_param.
// Latency: two instances share stimulus: a = RD_LAT 1 / write-first, b = RD_LAT 2 / read-old.
// Backpressure: clear-engine busy windows are measured and probed with dropped we/re.
module tb_dpram_ctrl_param;

  logic       clk;
  logic       reset;
  logic       clear_req;
  logic       we;
  logic [5:0] wr_addr;
  logic [7:0] data_in;
  logic       re;
  logic [5:0] rd_addr;

  logic [7:0] a_dout, b_dout;
  logic       a_vld, b_vld, a_busy, b_busy;

  int total = 0;
  int bad   = 0;
  int n, v;

  dpram_ctrl_param #(
    .DATA_W(8), .ADDR_W(6), .RD_LAT(1), .BYPASS(1), .INIT_VAL(8'hA5)
  ) dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .we(we), .wr_addr(wr_addr), .data_in(data_in),
    .re(re), .rd_addr(rd_addr),
    .data_out(a_dout), .rd_valid(a_vld), .busy(a_busy)
  );

  dpram_ctrl_param #(
    .DATA_W(8), .ADDR_W(6), .RD_LAT(2), .BYPASS(0), .INIT_VAL(8'hA5)
  ) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .we(we), .wr_addr(wr_addr), .data_in(data_in),
    .re(re), .rd_addr(rd_addr),
    .data_out(b_dout), .rd_valid(b_vld), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 3 + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until busy falls (bounded); optional clear_req pulse at a given count.
  task automatic wait_ready(input int pulse_at, output int cycles, output int vlds);
    cycles = 0;
    vlds   = 0;
    do begin
      clear_req = (cycles == pulse_at);
      step();
      cycles++;
      if (a_vld || b_vld) vlds++;
    end while (a_busy && cycles < 200);
    clear_req = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; wr_addr = 6'(i); data_in = pat(i);
      step();
    end
    we = 1'b0;
  endtask

  // Reads 0..63 with re held high; a lands one cycle after issue, b two.
  task automatic stream(input bit use_pat);
    int na, nb;
    logic [7:0] e;
    na = 0; nb = 0;
    for (int i = 0; i < 66; i++) begin
      re = (i < 64); rd_addr = 6'(i);
      step();
      if (a_vld) na++;
      if (b_vld) nb++;
      if (i < 64) begin
        e = use_pat ? pat(i) : 8'hA5;
        chk("a_stream_dat", {24'd0, a_dout}, {24'd0, e});
      end
      if (i >= 1 && i <= 64) begin
        e = use_pat ? pat(i - 1) : 8'hA5;
        chk("b_stream_dat", {24'd0, b_dout}, {24'd0, e});
      end
    end
    re = 1'b0;
    chk("a_stream_pulses", na, 64);
    chk("b_stream_pulses", nb, 64);
  endtask

  initial begin
    reset = 1'b1; clear_req = 1'b0; we = 1'b0; re = 1'b0;
    wr_addr = '0; rd_addr = '0; data_in = '0;

    // Reset state
    #1;
    chk("rst_a_busy", a_busy, 1);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_a_vld",  a_vld,  0);
    chk("rst_b_dout", b_dout, 0);
    chk("rst_b_vld",  b_vld,  0);
    step();
    reset = 1'b0;

    // Power-up clear: 64 busy cycles, then every word reads INIT_VAL
    wait_ready(-1, n, v);
    chk("init_clear_cycles", n, 64);
    chk("init_b_busy", b_busy, 0);
    stream(1'b0);

    // Simple write then read, both latencies
    we = 1'b1; wr_addr = 6'd5; data_in = 8'h3C;
    step();
    we = 1'b0; re = 1'b1; rd_addr = 6'd5;
    step();
    re = 1'b0;
    chk("lat_a_dout", a_dout, 8'h3C);
    chk("lat_a_vld",  a_vld,  1);
    chk("lat_b_vld0", b_vld,  0);
    step();
    chk("lat_a_vld_drop", a_vld, 0);
    chk("lat_a_hold",     a_dout, 8'h3C);
    chk("lat_b_dout",     b_dout, 8'h3C);
    chk("lat_b_vld",      b_vld,  1);
    step();
    chk("lat_b_vld_drop", b_vld, 0);
    chk("lat_b_hold",     b_dout, 8'h3C);

    // Read-during-write collision on address 9
    we = 1'b1; wr_addr = 6'd9; data_in = 8'h11;
    step();
    re = 1'b1; rd_addr = 6'd9; data_in = 8'h22;
    step();
    we = 1'b0; re = 1'b0;
    chk("rdw_bypass", a_dout, 8'h22);
    chk("rdw_a_vld",  a_vld,  1);
    step();
    chk("rdw_old",    b_dout, 8'h11);
    chk("rdw_b_vld",  b_vld,  1);
    chk("rdw_a_vld0", a_vld,  0);
    // Re-read, with an unrelated write to a different address in the same cycle
    re = 1'b1; rd_addr = 6'd9; we = 1'b1; wr_addr = 6'd10; data_in = 8'h33;
    step();
    we = 1'b0; re = 1'b0;
    chk("reread_a", a_dout, 8'h22);
    step();
    chk("reread_b", b_dout, 8'h22);

    // Streaming reads of distinct contents: in order, no gaps
    fill();
    stream(1'b1);

    // clear_req with a same-cycle read/write, then we/re held during busy
    clear_req = 1'b1; we = 1'b1; wr_addr = 6'd7; data_in = 8'h77;
    re = 1'b1; rd_addr = 6'd3;
    step();
    clear_req = 1'b0;
    chk("clr_busy",   a_busy, 1);
    chk("clr_a_vld",  a_vld,  1);
    chk("clr_a_dout", a_dout, pat(3));
    data_in = 8'h99;
    step();
    chk("clr_a_vld0",   a_vld,  0);
    chk("clr_b_inflt",  b_vld,  1);
    chk("clr_b_dout",   b_dout, pat(3));
    wait_ready(-1, n, v);
    we = 1'b0; re = 1'b0;
    chk("clr_cycles",   n + 1, 64);
    chk("clr_dropped",  v, 0);
    stream(1'b0);

    // Async reset mid-clear at clr_cnt=30; extra clear_req during restart is ignored
    fill();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (30) step();
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_a_dout", a_dout, 0);
    chk("mid_rst_b_dout", b_dout, 0);
    chk("mid_rst_a_vld",  a_vld,  0);
    chk("mid_rst_busy",   a_busy, 1);
    step();
    reset = 1'b0;
    wait_ready(10, n, v);
    chk("restart_cycles", n, 64);
    stream(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
